// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter for the write port of one afifo.
// A requester is granted only once the FIFO has room for its whole burst.
module afifo_wr_arb #(
    parameter int NR = 4,
    parameter int DW = 128,
    parameter int AW = 4,
    parameter int LW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR-1:0]    req_valid,
    input  logic [NR*LW-1:0] req_len,
    output logic [NR-1:0]    req_done,
    input  logic [NR-1:0]    s_valid,
    input  logic [NR*DW-1:0] s_data,
    output logic [NR-1:0]    s_ready,
    output logic             fifo_we,
    output logic [DW-1:0]    fifo_d,
    input  logic             fifo_wfull,
    input  logic [AW:0]      fifo_wcnt,
    output logic [NR-1:0]    grant,
    output logic             busy
);

    localparam int OW = $clog2(NR);
    localparam int FW = AW + 2;
    localparam int NW = ((LW > AW) ? LW : AW) + 2;
    localparam int CW = (NW > FW) ? NW : FW;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_last;
    logic [LW-1:0]   r_len_q;
    logic [LW-1:0]   r_cnt;
    logic [OW-1:0]   w_sel;
    logic            w_any;
    logic [LW-1:0]   w_sel_len;
    logic            w_last_beat;

    // An oversized burst is admitted only into an empty FIFO and then relies on wfull.
    function automatic logic f_fits(input logic [LW-1:0] len, input logic [AW:0] wcnt);
        logic [CW-1:0] need;
        logic [CW-1:0] free;
        logic [CW-1:0] depth;
        depth = CW'(1) << AW;
        need  = CW'(len) + CW'(1);
        free  = depth - CW'(wcnt);
        return (need <= free) || ((need > depth) && (wcnt == '0));
    endfunction

    always_comb begin
        logic [OW-1:0] cand;
        w_sel = '0;
        w_any = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NR; k++) begin
            cand = OW'((int'(r_last) + k) % NR);
            if (!w_any && req_valid[cand]) begin
                w_any = 1'b1;
                w_sel = cand;
            end
        end
    end

    assign w_sel_len   = req_len[int'(w_sel)*LW +: LW];
    assign w_last_beat = (r_cnt == r_len_q);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = f_fits(w_sel_len, fifo_wcnt) ? BURST : WAIT;
            WAIT:    if (f_fits(r_len_q, fifo_wcnt)) w_state_nxt = BURST;
            BURST:   if (fifo_we && w_last_beat) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        s_ready  = '0;
        req_done = '0;
        fifo_we  = 1'b0;
        fifo_d   = '0;
        if (r_state == BURST) begin
            grant[r_owner]    = 1'b1;
            s_ready[r_owner]  = ~fifo_wfull;
            fifo_we           = s_valid[r_owner] & ~fifo_wfull;
            fifo_d            = s_data[int'(r_owner)*DW +: DW];
            req_done[r_owner] = fifo_we & w_last_beat;
        end
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= OW'(NR - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == BURST && fifo_we) begin
                if (w_last_beat) begin
                    r_cnt  <= '0;
                    r_last <= r_owner;
                end else begin
                    r_cnt <= r_cnt + LW'(1);
                end
            end
        end
    end

    // Owner and length are pure data; they are always reloaded in IDLE before use.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_any) begin
            r_owner <= w_sel;
            r_len_q <= w_sel_len;
        end
    end

endmodule

// File: doc/afifo_wr_arb.md
Name: afifo_wr_arb

Overview:
- Round-robin burst arbiter that shares the write port of one afifo instance among NR requesters.
- Runs entirely in the FIFO write-clock domain.
- Grants a requester only when the FIFO has room for its whole burst, then streams that burst's beats into the FIFO.
- Sits between per-master write-data sources (for example AXI W channels) and the afifo `we`/`d`/`wfull`/`wcnt` pins.

Parameters:
- NR, 4: number of requesters, 2..16.
- DW, 128: data width; must equal the FIFO DW.
- AW, 4: FIFO address width; depth is 2**AW. Must equal the FIFO AW.
- LW, 8: burst length field width. The length is encoded as beats-1.

Ports:
- clk  in  1  write-side clock; same clock as the FIFO wclk.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NR  per-requester burst request; held high until that requester's req_done.
- req_len  in  NR*LW  per-requester burst length as beats-1; slice i is [i*LW +: LW].
- req_done  out  NR  one-cycle pulse on the cycle the requester's last beat is written.
- s_valid  in  NR  per-requester beat valid.
- s_data  in  NR*DW  per-requester beat data; slice i is [i*DW +: DW].
- s_ready  out  NR  per-requester beat ready.
- fifo_we  out  1  to afifo `we`.
- fifo_d  out  DW  to afifo `d`.
- fifo_wfull  in  1  from afifo `wfull`.
- fifo_wcnt  in  AW+1  from afifo `wcnt`; occupancy seen from the write side.
- grant  out  NR  one-hot current owner; all zero when not in BURST.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset:
  - state goes to IDLE; grant, s_ready, req_done, fifo_we and busy are 0; fifo_d is 0.
  - The beat counter is cleared.
  - The round-robin pointer last is set to NR-1, so requester 0 has highest priority first.
  - Reset mid-burst abandons the burst: no req_done is issued and beats already written stay in the FIFO.
- free = 2**AW - fifo_wcnt, computed in AW+2 bits.
- need = req_len[sel]+1, computed in max(LW,AW)+2 bits.
- fits = (need <= free) OR (need > 2**AW AND fifo_wcnt == 0).
  - An oversized burst waits for an empty FIFO, then proceeds under wfull flow control.
- State IDLE:
  - sel = first i with req_valid[i]=1, searching last+1, last+2, ... modulo NR.
  - If any request is present: latch sel into owner and req_len[sel] into len_q. Go to BURST if fits, else go to WAIT.
- State WAIT:
  - owner is locked; other requesters are not considered (no skipping, no starvation).
  - Each cycle re-evaluate fits using len_q; go to BURST when it holds.
- State BURST:
  - grant[owner]=1.
  - s_ready[owner] = ~fifo_wfull; every other s_ready bit is 0.
  - fifo_we = s_valid[owner] & ~fifo_wfull.
  - fifo_d = s_data[owner], combinational mux.
  - On each write the beat counter increments.
  - On the write where the counter equals len_q: pulse req_done[owner], set last=owner, clear the counter, go to IDLE.
- Latency:
  - A request arriving in IDLE with space enters BURST on the next cycle; the first beat can be written that cycle.
  - After the last beat there is at least one IDLE cycle, so fifo_wcnt already reflects the completed burst before the next fits check.
- fifo_wcnt lags on the read side only, so occupancy is overestimated and grants are always safe. fifo_we is still gated by fifo_wfull.
- Dropping req_valid[owner] during WAIT or BURST is a protocol violation; the arbiter continues the locked burst regardless.
- s_valid of non-owners is ignored; their data is never forwarded.
- When the selected requester's req_valid and other requesters' req_valid change in the same cycle, only the IDLE-cycle sampled values matter.

Test Plan:
- Single requester: AW=4, req 0 with len=3, FIFO empty → BURST one cycle after req_valid. Exactly 4 fifo_we pulses with data D0..D3 in order. req_done[0] pulses on the 4th write. busy falls the next cycle.
- Round-robin fairness: all 4 requesters request continuously with len=0, FIFO drained → grant order 0,1,2,3,0,1. Exactly one IDLE cycle between grants.
- Space gating: fifo_wcnt=14 (free=2), req 1 with len=3 → stays in WAIT with no fifo_we. When fifo_wcnt drops to 12, it enters BURST the next cycle and writes 4 beats.
- No skipping: req 2 waits with len=7 while req 3 with len=0 is pending and the FIFO has space for only 1 beat → req 3 is not granted until req 2's burst completes.
- Backpressure: during BURST, hold fifo_wfull high for 3 cycles → s_ready and fifo_we stay 0 during those cycles, the beat counter holds, and the burst resumes with no duplicated or lost beats.
- Reset mid-burst: assert reset after 2 of 8 beats → the next cycle shows all outputs 0 and state IDLE with no req_done. After reset release, requester 0 wins over requester 1.
